// File: rtl/solar_pkg.sv
// Shared types for the solar tracker motor scheduler: FSM state encoding and
// the axis / direction codes driven onto the motor driver pins.
package solar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEAD,
      ST_RUN,
      ST_BRAKE,
      ST_COOL
   } state_t;

   localparam logic AXIS_NS = 1'b0;
   localparam logic AXIS_EW = 1'b1;
   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/solar_dwell_timer.sv
// Dwell counter for the scheduler: counts up from zero after every clear and
// flags the last cycle (done) and any cycle at or past it (ge) of a dwell.
module solar_dwell_timer #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [CW-1:0] limit,
   output logic [CW-1:0] cnt,
   output logic          done,
   output logic          ge
);

   logic [CW-1:0] last;

   assign last = limit - CW'(1);
   assign done = (cnt == last);
   assign ge   = (cnt >= last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/solar_motor_sched.sv
// Schedules N/E/S/W tracker requests onto one shared motor driver with dead
// time, minimum/maximum on-time and a cooldown after a timeout.
module solar_motor_sched
   import solar_pkg::*;
#(
   parameter int CW       = 16,
   parameter int DEAD_CYC = 16,
   parameter int MIN_ON   = 64,
   parameter int MAX_ON   = 4096,
   parameter int COOL_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_n,
   input  logic req_s,
   input  logic req_e,
   input  logic req_w,
   output logic drv_en,
   output logic drv_axis,
   output logic drv_dir,
   output logic busy,
   output logic timeout
);

   localparam logic [CW-1:0] DEAD_L   = CW'(DEAD_CYC);
   localparam logic [CW-1:0] MIN_L    = CW'(MIN_ON);
   localparam logic [CW-1:0] COOL_L   = CW'(COOL_CYC);
   localparam logic [CW-1:0] MAX_LAST = CW'(MAX_ON - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, limit;
   logic          done, ge, clr;
   logic          last_axis;
   logic          ns_valid, ew_valid;
   logic          req_lat, req_opp, release_c;
   logic          gnt, gnt_axis, gnt_dir, tmo_nx;

   assign ns_valid = req_n ^ req_s;
   assign ew_valid = req_e ^ req_w;

   // drv_axis/drv_dir double as the latched grant while DEAD/RUN are active
   assign req_lat   = (drv_axis == AXIS_EW) ? ((drv_dir == DIR_NEG) ? req_w : req_e)
                                            : ((drv_dir == DIR_NEG) ? req_s : req_n);
   assign req_opp   = (drv_axis == AXIS_EW) ? ((drv_dir == DIR_NEG) ? req_e : req_w)
                                            : ((drv_dir == DIR_NEG) ? req_n : req_s);
   assign release_c = !req_lat || req_opp;

   assign clr  = (state_nx != state);
   assign busy = (state != ST_IDLE);

   solar_dwell_timer #(.CW(CW)) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .limit (limit),
      .cnt   (cnt),
      .done  (done),
      .ge    (ge)
   );

   always_comb begin
      state_nx = state;
      limit    = DEAD_L;
      gnt      = 1'b0;
      gnt_axis = drv_axis;
      gnt_dir  = drv_dir;
      tmo_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && (ns_valid || ew_valid)) begin
               gnt      = 1'b1;
               gnt_axis = (ns_valid && ew_valid) ? ~last_axis : ew_valid;
               gnt_dir  = gnt_axis ? req_w : req_s;
               state_nx = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (!en || release_c)
               state_nx = ST_IDLE;
            else if (done)
               state_nx = ST_RUN;
         end
         ST_RUN: begin
            // ge tracks MIN_ON here; the MAX_ON limit is compared directly
            limit = MIN_L;
            if (!en)
               state_nx = ST_BRAKE;
            else if (cnt == MAX_LAST) begin
               state_nx = ST_COOL;
               tmo_nx   = 1'b1;
            end else if (release_c && ge)
               state_nx = ST_BRAKE;
         end
         ST_BRAKE: begin
            if (done)
               state_nx = ST_IDLE;
         end
         ST_COOL: begin
            limit = COOL_L;
            if (done)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         drv_en    <= 1'b0;
         drv_axis  <= AXIS_NS;
         drv_dir   <= DIR_POS;
         timeout   <= 1'b0;
         last_axis <= AXIS_EW;
      end else begin
         state   <= state_nx;
         drv_en  <= (state_nx == ST_RUN);
         timeout <= tmo_nx;
         if (gnt) begin
            drv_axis  <= gnt_axis;
            drv_dir   <= gnt_dir;
            last_axis <= gnt_axis;
         end
      end
   end

endmodule

// File: tb/tb_solar_motor_sched.sv
// Randomized bench for solar_motor_sched: every busy interval is summarised by
// a monitor and compared against a record predicted from the scheduling rules.
module tb_solar_motor_sched;

   localparam int DEAD_CYC = 16;
   localparam int MIN_ON   = 64;
   localparam int MAX_ON   = 4096;
   localparam int COOL_CYC = 1024;
   localparam int TW       = 24;
   localparam int REC_W    = 5 + 3 * TW;

   logic clk = 1'b0;
   logic rst, en, req_n, req_s, req_e, req_w;
   logic drv_en, drv_axis, drv_dir, busy, timeout;

   solar_motor_sched #(
      .CW(16), .DEAD_CYC(DEAD_CYC), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .COOL_CYC(COOL_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req_n    (req_n),
      .req_s    (req_s),
      .req_e    (req_e),
      .req_w    (req_w),
      .drv_en   (drv_en),
      .drv_axis (drv_axis),
      .drv_dir  (drv_dir),
      .busy     (busy),
      .timeout  (timeout)
   );

   // clock / reset / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [REC_W-1:0] exp_q[$];
   bit model_last_axis;
   int rand_timeouts = 0;

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // one busy interval: {had_run, axis, dir, timeout pulses, rise, fall, idle cycle}
   function automatic logic [REC_W-1:0] mk(bit run, bit axis, bit dir, int tmo,
                                           int rise, int fall, int idle);
      return {run, axis, dir, tmo[1:0], rise[TW-1:0], fall[TW-1:0], idle[TW-1:0]};
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic set_req(bit n, bit s, bit e, bit w);
      req_n = n; req_s = s; req_e = e; req_w = w;
   endtask

   // Reference: RUN starts at cycle r; the stop cause is seen at RUN offset k
   // (k < 0 means during dead time). Release honours MIN_ON, en-drop does not,
   // and holding until offset MAX_ON-1 gives a timeout followed by cooldown.
   task automatic push_run(bit axis, bit dir, int r, int k, bit by_en);
      int len, fall;
      bit tmo;
      tmo = 1'b0;
      if (k < 0) begin
         exp_q.push_back(mk(1'b0, axis, dir, 0, 0, 0, r + k + 1));
      end else begin
         if (by_en)
            len = k + 1;
         else if (k >= MAX_ON - 1) begin
            len = MAX_ON;
            tmo = 1'b1;
         end else
            len = ((k > MIN_ON - 1) ? k : MIN_ON - 1) + 1;
         fall = r + len;
         exp_q.push_back(mk(1'b1, axis, dir, tmo ? 1 : 0, r, fall,
                            fall + (tmo ? COOL_CYC : DEAD_CYC)));
      end
   endtask

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      check("idle_reached", busy, 0);
   endtask

   // pat 0..3: single N/S/E/W request; pat 4: one request on each axis
   task automatic episode(int pat, int k, bit by_en);
      bit ns_v, ew_v, nsd, ewd, axis, dir;
      int c, r;
      nsd  = 1'($urandom_range(0, 1));
      ewd  = 1'($urandom_range(0, 1));
      ns_v = (pat == 0 || pat == 1 || pat == 4);
      ew_v = (pat == 2 || pat == 3 || pat == 4);
      if (pat == 0) nsd = 1'b0;
      if (pat == 1) nsd = 1'b1;
      if (pat == 2) ewd = 1'b0;
      if (pat == 3) ewd = 1'b1;
      axis = (ns_v && ew_v) ? ~model_last_axis : ew_v;
      dir  = axis ? ewd : nsd;
      model_last_axis = axis;
      c = cyc;
      set_req(ns_v && !nsd, ns_v && nsd, ew_v && !ewd, ew_v && ewd);
      r = c + 1 + DEAD_CYC;
      tick(r + k - c);
      set_req(0, 0, 0, 0);
      if (by_en) en = 1'b0;
      push_run(axis, dir, r, k, by_en);
      wait_idle(MAX_ON + COOL_CYC + 100);
      tick(1);
      en = 1'b1;
      tick(1);
   endtask

   // N and E together: the round-robin winner runs first, the other axis is
   // granted from the IDLE cycle that follows its brake
   task automatic two_axis_sequence();
      bit a1;
      int c, r, idle1, r2;
      a1 = ~model_last_axis;
      c = cyc;
      set_req(1, 0, 1, 0);
      r = c + 1 + DEAD_CYC;
      tick(r + 10 - c);
      if (a1) req_e = 1'b0; else req_n = 1'b0;
      push_run(a1, 1'b0, r, 10, 1'b0);
      idle1 = r + MIN_ON + DEAD_CYC;
      r2 = idle1 + 1 + DEAD_CYC;
      tick(r2 + 5 - cyc);
      set_req(0, 0, 0, 0);
      push_run(~a1, 1'b0, r2, 5, 1'b0);
      model_last_axis = ~a1;
      wait_idle(500);
      tick(2);
   endtask

   // monitor: summarises each busy interval and checks it against the queue
   initial begin : monitor
      bit act, had_run, prev_en, m_axis, m_dir;
      int m_rise, m_fall, m_tmo;
      logic [REC_W-1:0] got, exp;
      act = 0; prev_en = 0; had_run = 0; m_axis = 0; m_dir = 0;
      m_rise = 0; m_fall = 0; m_tmo = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 0;
            prev_en = 0;
         end else begin
            if (busy && !act) begin
               act = 1; had_run = 0; m_rise = 0; m_fall = 0; m_tmo = 0;
               m_axis = drv_axis; m_dir = drv_dir;
            end
            if (act) begin
               if (drv_en && !prev_en) begin had_run = 1; m_rise = cyc; end
               if (!drv_en && prev_en) m_fall = cyc;
               if (timeout && m_tmo < 3) m_tmo++;
               if (!busy) begin
                  got = mk(had_run, m_axis, m_dir, m_tmo, m_rise, m_fall, cyc);
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL busy_interval unexpected got=%h at cycle %0d", got, cyc);
                  end else begin
                     exp = exp_q.pop_front();
                     if (got !== exp) begin
                        errors++;
                        $display("FAIL busy_interval got=%h expected=%h (run axis dir tmo rise fall idle) at cycle %0d",
                                 got, exp, cyc);
                     end
                  end
                  act = 0;
               end
            end
            prev_en = drv_en;
         end
      end
   end

   // driver
   initial begin : driver
      bit seen_busy;
      int pat, k, sel;
      bit by_en;
      rst = 1'b1; en = 1'b1;
      set_req(0, 0, 0, 0);
      tick(3);
      check("rst_drv_en", drv_en, 0);
      check("rst_drv_axis", drv_axis, 0);
      check("rst_drv_dir", drv_dir, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      rst = 1'b0;
      model_last_axis = 1'b1;
      tick(1);

      // single north request, released early: MIN_ON stretch then brake
      episode(0, 10, 1'b0);

      // conflicting requests on one axis are never granted
      set_req(1, 1, 0, 0);
      seen_busy = 0;
      repeat (40) begin
         tick(1);
         if (busy) seen_busy = 1;
      end
      check("conflict_no_grant", seen_busy, 0);
      set_req(0, 0, 0, 0);
      tick(2);

      // east held through timeout, cooldown and the following re-grant
      begin
         int c, r, idle1, r2;
         c = cyc;
         set_req(0, 0, 1, 0);
         r = c + 1 + DEAD_CYC;
         push_run(1'b1, 1'b0, r, MAX_ON - 1, 1'b0);
         idle1 = r + MAX_ON + COOL_CYC;
         r2 = idle1 + 1 + DEAD_CYC;
         tick(r2 + 20 - c);
         set_req(0, 0, 0, 0);
         push_run(1'b1, 1'b0, r2, 20, 1'b0);
         model_last_axis = 1'b1;
         wait_idle(MAX_ON + COOL_CYC + 200);
         tick(2);
      end

      // en dropped at RUN offset 5 overrides MIN_ON
      episode(0, 5, 1'b1);

      // en low in IDLE blocks grants
      en = 1'b0;
      set_req(1, 0, 0, 0);
      seen_busy = 0;
      repeat (30) begin
         tick(1);
         if (busy) seen_busy = 1;
      end
      check("en_low_no_grant", seen_busy, 0);
      set_req(0, 0, 0, 0);
      en = 1'b1;
      tick(2);

      // asynchronous reset in the middle of a run
      set_req(0, 0, 0, 1);
      tick(1 + DEAD_CYC + 20);
      check("pre_rst_running", drv_en, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_drv_en", drv_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_axis", drv_axis, 0);
      check("mid_rst_dir", drv_dir, 0);
      check("mid_rst_timeout", timeout, 0);
      set_req(0, 0, 0, 0);
      tick(2);
      rst = 1'b0;
      model_last_axis = 1'b1;
      tick(2);

      // both axes right after reset: NS first, then EW
      two_axis_sequence();

      // randomized episodes
      repeat (30) begin
         pat   = $urandom_range(0, 4);
         by_en = ($urandom_range(0, 3) == 0);
         sel   = $urandom_range(0, 9);
         if (sel == 0 && !by_en && rand_timeouts < 2) begin
            k = $urandom_range(MAX_ON - 1, MAX_ON + 50);
            rand_timeouts++;
         end else if (sel < 3)
            k = -int'($urandom_range(1, DEAD_CYC));
         else
            k = $urandom_range(0, 150);
         episode(pat, k, by_en);
      end
      two_axis_sequence();

      tick(5);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
